pwm_compare_ctrl: RTL

- Control and compare stage wrapped around the loadable up-counter.
- Drives the counter's en/load/data inputs so the counter wraps at a programmable period.
- Consumes the counter's count value and produces a registered PWM output plus a wrap pulse.
- Period/duty updates arrive over a valid/ready handshake and are double-buffered, so they take effect only at a period boundary.

---
 rtl/pwm_compare_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_compare_ctrl.sv
// pwm_compare_ctrl
// Control and compare stage for an external loadable up-counter. Steers the
// counter's en/load/data so it wraps at a programmable period. Derives a
// registered PWM output and a wrap pulse from the returned count.
// Period/duty updates arrive over valid/ready into a one-deep shadow
// register. They are applied only at a period boundary, or straight away
// while idle.
//
// Optional build macro: PWM_ONESHOT_EN adds oneshot_i. When oneshot_i is set
// at start, the block runs a single period and then needs en_i to fall and
// rise again before it restarts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | counter held at 0, pwm low; waits for en_i with period != 0
// RUN      | counting 0..period_q and wrapping; pwm/wrap active
// STOPPING | en_i dropped; finish the current period, then go to IDLE

module pwm_compare_ctrl #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] cnt_i,
    input  logic [Width-1:0] period_i,
    input  logic [Width-1:0] duty_i,
`ifdef PWM_ONESHOT_EN
    input  logic             oneshot_i,
`endif
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    output logic             cnt_en_o,
    output logic             cnt_load_o,
    output logic [Width-1:0] cnt_data_o,
    output logic             pwm_o,
    output logic             wrap_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [Width-1:0] r_period_q;
    logic [Width-1:0] r_duty_q;
    logic [Width-1:0] r_shadow_period;
    logic [Width-1:0] r_shadow_duty;
    logic             r_pend;
    logic             r_pwm;
    logic             r_wrap;

    logic             w_tc;
    logic             w_busy;
    logic             w_accept;
    logic             w_xfer;
    logic             w_period_nz;
    logic             w_os_flag;
    logic             w_os_block;

    assign w_tc        = (cnt_i == r_period_q);
    assign w_busy      = (r_state != S_IDLE);
    assign w_period_nz = (r_period_q != '0);
    assign w_accept    = upd_valid_i && !r_pend;
    // While idle the shadow is applied on the next edge; while counting it
    // waits for the terminal count so a period is never cut short.
    assign w_xfer      = r_pend && (!w_busy || w_tc);

`ifdef PWM_ONESHOT_EN
    logic r_oneshot;
    logic r_os_block;
    logic w_os_done;

    assign w_os_done  = w_busy && w_tc && r_oneshot;
    assign w_os_flag  = r_oneshot;
    assign w_os_block = r_os_block;

    // Oneshot flag is latched at start and dropped whenever we return to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_oneshot <= 1'b0;
        end else if (r_state == S_IDLE && w_state_nxt == S_RUN) begin
            r_oneshot <= oneshot_i;
        end else if (w_state_nxt == S_IDLE) begin
            r_oneshot <= 1'b0;
        end
    end

    // After a oneshot completes, block restart until en_i has been seen low.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_os_block <= 1'b0;
        end else begin
            r_os_block <= en_i && (r_os_block || w_os_done);
        end
    end
`else
    assign w_os_flag  = 1'b0;
    assign w_os_block = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. STOPPING goes back to RUN when en_i returns, without
    // touching the count; at tc it only leaves for IDLE if en_i is still low.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en_i && w_period_nz && !w_os_block) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_tc && (!en_i || w_os_flag)) begin
                    w_state_nxt = S_IDLE;
                end else if (!en_i) begin
                    w_state_nxt = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (w_tc && (!en_i || w_os_flag)) begin
                    w_state_nxt = S_IDLE;
                end else if (en_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shadow capture on handshake, and transfer into the active registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_shadow_period <= '0;
            r_shadow_duty   <= '0;
            r_period_q      <= '0;
            r_duty_q        <= '0;
            r_pend          <= 1'b0;
        end else if (w_xfer) begin
            r_period_q <= r_shadow_period;
            r_duty_q   <= r_shadow_duty;
            r_pend     <= 1'b0;
        end else if (w_accept) begin
            r_shadow_period <= period_i;
            r_shadow_duty   <= duty_i;
            r_pend          <= 1'b1;
        end
    end

    // Registered compare outputs, one cycle behind cnt_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pwm  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_pwm  <= w_busy && (cnt_i < r_duty_q);
            r_wrap <= w_busy && w_tc;
        end
    end

    // Counter drive is gated by reset so the counter freezes while rst_i is low.
    assign cnt_en_o    = rst_i;
    assign cnt_load_o  = rst_i && (!w_busy || w_tc);
    assign cnt_data_o  = '0;
    assign upd_ready_o = !r_pend;
    assign busy_o      = w_busy;
    assign pwm_o       = r_pwm;
    assign wrap_o      = r_wrap;

endmodule
